buzzer_tone_gen: RTL and testbench

// - Consumes the 6-bit note code emitted by the game's sound sequencer and drives the piezo buzzer pin with a square wave.
// - Note codes arrive from the slow sequencer domain, so the block synchronises and debounces them.
// - Each accepted code is mapped to a half-period count, and a phase counter toggles the output.
// - Sits between the sequencer and the board buzzer pad, running on the 100 MHz board clock.

---
 rtl/buzzer_pkg.sv | 29 ++
 rtl/buzzer_note_rom.sv | 20 ++
 rtl/buzzer_tone_gen.sv | 94 +++++++++
 tb/tb_buzzer_tone_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared constants and the note-code to half-period mapping for the buzzer tone generator.
// The mapping is a pure function so the ROM and any reference logic agree by construction.
package buzzer_pkg;

  localparam logic [5:0] NOTE_SILENT   = 6'd0;
  localparam int         NOTES_PER_OCT = 12;

  // C4..B4 in millihertz; higher octaves are derived by right-shifting the half-period.
  localparam int unsigned BASE_MHZ [0:11] = '{
    261626, 277183, 293665, 311127, 329628, 349228,
    369994, 391995, 415305, 440000, 466164, 493883
  };

  function automatic logic [31:0] note_half_period(input logic [5:0] n,
                                                   input int unsigned clk_hz);
    logic [5:0]  nm1;
    logic [3:0]  idx;
    logic [2:0]  oct;
    logic [63:0] num;
    if (n == NOTE_SILENT) return 32'd0;
    nm1 = n - 6'd1;
    idx = 4'(nm1 % 6'(NOTES_PER_OCT));
    oct = 3'(nm1 / 6'(NOTES_PER_OCT));
    // half-period = clk_hz / (2 * f) with f in mHz -> clk_hz * 500 / f_mhz
    num = 64'(clk_hz) * 64'd500;
    return 32'((num / 64'(BASE_MHZ[idx])) >> oct);
  endfunction

endpackage

// File: rtl/buzzer_note_rom.sv
// Combinational lookup from 6-bit note code to half-period in clk cycles.
// Kept separate so the map can be exercised on its own.
module buzzer_note_rom
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned HALF_W = 24
) (
  input  logic [5:0]        note_i,
  output logic [HALF_W-1:0] half_o
);

  always_comb begin
    half_o = '0;
    for (int i = 0; i < 64; i++) begin
      if (note_i == 6'(i)) half_o = HALF_W'(note_half_period(6'(i), CLK_HZ));
    end
  end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Piezo square-wave generator: synchronises and qualifies the sequencer note code,
// maps it to a half-period and toggles the buzzer pad from a phase counter.
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned HALF_W = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enabled,
  input  logic [5:0] note,
  output logic       buzzer,
  output logic       tone_on,
  output logic [5:0] note_cur
);

  logic [5:0]        s1_q, s2_q, s3_q;
  logic              en_q;
  logic [5:0]        note_cur_q, note_cur_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              buzzer_q, buzzer_d;
  logic              tone_on_q, tone_on_d;
  logic [HALF_W-1:0] period_w;
  logic              accept_w;

  buzzer_note_rom #(
    .CLK_HZ (CLK_HZ),
    .HALF_W (HALF_W)
  ) u_rom (
    .note_i (s2_q),
    .half_o (period_w)
  );

  // A code is taken only once it has survived two consecutive samples.
  assign accept_w = (s2_q == s3_q) && (s2_q != note_cur_q);

  always_comb begin
    note_cur_d = note_cur_q;
    half_d     = half_q;
    cnt_d      = cnt_q;
    buzzer_d   = buzzer_q;
    tone_on_d  = tone_on_q;
    if (accept_w) begin
      note_cur_d = s2_q;
      half_d     = period_w;
      cnt_d      = '0;
      buzzer_d   = (s2_q != NOTE_SILENT) && enabled;
      tone_on_d  = (s2_q != NOTE_SILENT);
    end else if (!tone_on_q || !enabled) begin
      cnt_d    = '0;
      buzzer_d = 1'b0;
    end else if (!en_q) begin
      // Re-enable starts a fresh high phase rather than resuming mid-period.
      cnt_d    = '0;
      buzzer_d = 1'b1;
    end else if (cnt_q == half_q - HALF_W'(1)) begin
      cnt_d    = '0;
      buzzer_d = ~buzzer_q;
    end else begin
      cnt_d = cnt_q + HALF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      en_q       <= 1'b0;
      note_cur_q <= '0;
      half_q     <= '0;
      cnt_q      <= '0;
      buzzer_q   <= 1'b0;
      tone_on_q  <= 1'b0;
    end else begin
      s1_q       <= note;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      en_q       <= enabled;
      note_cur_q <= note_cur_d;
      half_q     <= half_d;
      cnt_q      <= cnt_d;
      buzzer_q   <= buzzer_d;
      tone_on_q  <= tone_on_d;
    end
  end

  assign buzzer   = buzzer_q;
  assign tone_on  = tone_on_q;
  assign note_cur = note_cur_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen at a 1 MHz nominal clock, plus a standalone sweep
// of buzzer_note_rom against hand-computed half-periods.
module tb_buzzer_tone_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enabled;
  logic [5:0] note;
  logic       buzzer;
  logic       tone_on;
  logic [5:0] note_cur;

  logic [5:0]  rom_note;
  logic [23:0] rom_half;

  int n_cmp = 0;
  int n_err = 0;

  // floor(500e6 / BASE_MHZ[idx]) worked out by hand for CLK_HZ = 1 MHz
  int base_half [12] = '{1911, 1803, 1702, 1607, 1516, 1431,
                         1351, 1275, 1203, 1136, 1072, 1012};

  buzzer_tone_gen #(
    .CLK_HZ (1_000_000),
    .HALF_W (24)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enabled  (enabled),
    .note     (note),
    .buzzer   (buzzer),
    .tone_on  (tone_on),
    .note_cur (note_cur)
  );

  buzzer_note_rom #(
    .CLK_HZ (1_000_000),
    .HALF_W (24)
  ) rom (
    .note_i (rom_note),
    .half_o (rom_half)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycles until buzzer leaves its current level (capped so a stuck output cannot hang).
  task automatic time_level(output int n);
    logic start;
    start = buzzer;
    n = 0;
    while (buzzer === start && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_note(input logic [5:0] exp, output int n);
    n = 0;
    while (note_cur !== exp && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int sum_hi, sum_lo;
    int exp_half;
    logic saw_high;

    reset_n = 1'b0;
    enabled = 1'b1;
    note    = 6'd10;
    rom_note = 6'd0;
    repeat (3) @(negedge clk);
    check("reset_buzzer", int'(buzzer), 0);
    check("reset_tone_on", int'(tone_on), 0);
    check("reset_note_cur", int'(note_cur), 0);

    // One edge captures the code, three more qualify and accept it.
    reset_n = 1'b1;
    n = 0;
    while (buzzer !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("release_rise_edges", n, 4);
    check("release_tone_on", int'(tone_on), 1);
    check("release_note_cur", int'(note_cur), 10);

    time_level(n);
    check("a4_first_high", n, 1136);
    sum_hi = 0;
    sum_lo = 0;
    for (int p = 0; p < 10; p++) begin
      time_level(n);
      sum_lo += n;
      time_level(n);
      sum_hi += n;
    end
    check("a4_10per_low", sum_lo, 11360);
    check("a4_10per_high", sum_hi, 11360);

    note = 6'd1;
    wait_note(6'd1, n);
    check("c4_accept_edges", n, 4);
    check("c4_accept_buzzer", int'(buzzer), 1);
    time_level(n);
    check("c4_high", n, 1911);
    time_level(n);
    check("c4_low", n, 1911);

    // Counter is at 500 when the new code is applied; the accept must restart phase 0.
    repeat (500) @(negedge clk);
    note = 6'd13;
    wait_note(6'd13, n);
    check("c5_accept_edges", n, 4);
    time_level(n);
    check("c5_restart_high", n, 955);
    time_level(n);
    check("c5_low", n, 955);

    note = 6'd0;
    wait_note(6'd0, n);
    check("silence_edges", n, 4);
    check("silence_tone_on", int'(tone_on), 0);
    check("silence_buzzer", int'(buzzer), 0);
    saw_high = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (buzzer) saw_high = 1'b1;
    end
    check("silence_hold", int'(saw_high), 0);

    note = 6'd10;
    wait_note(6'd10, n);
    check("glitch_pre_accept", int'(note_cur), 10);
    repeat (100) @(negedge clk);
    note = 6'd5;
    @(negedge clk);
    note = 6'd10;
    time_level(n);
    check("glitch_high_remaining", n, 1035);
    check("glitch_note_cur", int'(note_cur), 10);
    time_level(n);
    check("glitch_low", n, 1136);

    enabled = 1'b0;
    @(negedge clk);
    check("disable_buzzer", int'(buzzer), 0);
    check("disable_tone_on", int'(tone_on), 1);
    saw_high = 1'b0;
    repeat (3000) begin
      @(negedge clk);
      if (buzzer) saw_high = 1'b1;
    end
    check("disable_hold", int'(saw_high), 0);
    enabled = 1'b1;
    @(negedge clk);
    check("enable_fresh_high", int'(buzzer), 1);
    time_level(n);
    check("enable_high", n, 1136);
    time_level(n);
    check("enable_low", n, 1136);

    // Acceptance keeps running while muted.
    enabled = 1'b0;
    note = 6'd13;
    wait_note(6'd13, n);
    check("muted_accept_note", int'(note_cur), 13);
    check("muted_accept_buzzer", int'(buzzer), 0);
    enabled = 1'b1;
    @(negedge clk);
    check("muted_enable_rise", int'(buzzer), 1);
    time_level(n);
    check("muted_enable_high", n, 955);

    reset_n = 1'b0;
    @(negedge clk);
    check("midtone_reset_buzzer", int'(buzzer), 0);
    check("midtone_reset_tone_on", int'(tone_on), 0);
    check("midtone_reset_note_cur", int'(note_cur), 0);
    reset_n = 1'b1;

    for (int k = 0; k < 64; k++) begin
      rom_note = 6'(k);
      #1;
      if (k == 0) exp_half = 0;
      else exp_half = base_half[(k - 1) % 12] >> ((k - 1) / 12);
      check($sformatf("rom_n%0d", k), int'(rom_half), exp_half);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
